// File: rtl/ysyx_22050133_axi_lsu_master.sv
// Single-outstanding AXI4 initiator: one LSU request becomes one single-beat AXI read or write.
// Optional misaligned-request rejection under YSYX_22050133_AXI_MST_ALIGN_CHECK_EN.
module ysyx_22050133_axi_lsu_master #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int ID_VAL         = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2:0]                  req_size,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  output logic                        axi_aw_valid_o,
  input  logic                        axi_aw_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
  output logic [7:0]                  axi_aw_len_o,
  output logic [2:0]                  axi_aw_size_o,
  output logic [1:0]                  axi_aw_burst_o,
  output logic                        axi_w_valid_o,
  input  logic                        axi_w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
  output logic                        axi_w_last_o,
  input  logic                        axi_b_valid_i,
  output logic                        axi_b_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i,
  input  logic [1:0]                  axi_b_resp_i,
  output logic                        axi_ar_valid_o,
  input  logic                        axi_ar_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o,
  output logic [7:0]                  axi_ar_len_o,
  output logic [2:0]                  axi_ar_size_o,
  output logic [1:0]                  axi_ar_burst_o,
  input  logic                        axi_r_valid_i,
  output logic                        axi_r_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id_i,
  input  logic [1:0]                  axi_r_resp_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i,
  input  logic                        axi_r_last_i
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RSP} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                size_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic                      aw_done_q, w_done_q;
  logic                      req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs, rsp_hs;
  logic                      aw_fin, w_fin, misaligned;
  logic                      unused_in;

  // len = 0 means r_last and the response IDs carry no information
  assign unused_in = ^{axi_r_last_i, axi_r_id_i, axi_b_id_i};

  assign req_hs = req_valid & req_ready;
  assign ar_hs  = axi_ar_valid_o & axi_ar_ready_i;
  assign r_hs   = axi_r_valid_i & axi_r_ready_o;
  assign aw_hs  = axi_aw_valid_o & axi_aw_ready_i;
  assign w_hs   = axi_w_valid_o & axi_w_ready_i;
  assign b_hs   = axi_b_valid_i & axi_b_ready_o;
  assign rsp_hs = rsp_valid & rsp_ready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

`ifdef YSYX_22050133_AXI_MST_ALIGN_CHECK_EN
  logic [AXI_ADDR_WIDTH-1:0] align_mask;
  assign align_mask = (AXI_ADDR_WIDTH'(1) << req_size) - AXI_ADDR_WIDTH'(1);
  assign misaligned = |(req_addr & align_mask);
`else
  assign misaligned = 1'b0;
`endif

  assign axi_aw_id_o    = AXI_ID_WIDTH'(ID_VAL);
  assign axi_ar_id_o    = AXI_ID_WIDTH'(ID_VAL);
  assign axi_aw_len_o   = 8'd0;
  assign axi_ar_len_o   = 8'd0;
  assign axi_aw_burst_o = 2'b01;
  assign axi_ar_burst_o = 2'b01;
  assign axi_w_last_o   = 1'b1;
  assign axi_aw_addr_o  = addr_q;
  assign axi_ar_addr_o  = addr_q;
  assign axi_aw_size_o  = size_q;
  assign axi_ar_size_o  = size_q;
  assign axi_w_data_o   = wdata_q;
  assign axi_w_strb_o   = wstrb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_hs) state_d = misaligned ? S_RSP : (req_we ? S_AW_W : S_AR);
      S_AR:   if (ar_hs) state_d = S_R;
      S_R:    if (r_hs) state_d = S_RSP;
      S_AW_W: if (aw_fin && w_fin) state_d = S_B;
      S_B:    if (b_hs) state_d = S_RSP;
      S_RSP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valids/readies decode from registered state, so each rises the cycle after entry
  always_comb begin
    req_ready      = 1'b0;
    axi_ar_valid_o = 1'b0;
    axi_r_ready_o  = 1'b0;
    axi_aw_valid_o = 1'b0;
    axi_w_valid_o  = 1'b0;
    axi_b_ready_o  = 1'b0;
    rsp_valid      = 1'b0;
    unique case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_AR:   axi_ar_valid_o = 1'b1;
      S_R:    axi_r_ready_o = 1'b1;
      S_AW_W: begin
        axi_aw_valid_o = ~aw_done_q;
        axi_w_valid_o  = ~w_done_q;
      end
      S_B:    axi_b_ready_o = 1'b1;
      S_RSP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (req_hs) begin
        addr_q    <= req_addr;
        size_q    <= req_size;
        wdata_q   <= req_wdata;
        wstrb_q   <= req_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (misaligned) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (r_hs) begin
        rsp_rdata <= axi_r_data_i;
        rsp_err   <= |axi_r_resp_i;
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_err   <= |axi_b_resp_i;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_axi_lsu_master.sv
// Bench for ysyx_22050133_axi_lsu_master: delay-configurable AXI slave, per-cycle output
// monitor against a transaction-level model, directed cases plus randomized traffic.
module tb_ysyx_22050133_axi_lsu_master;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [63:0] w_data, r_data;

  ysyx_22050133_axi_lsu_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_aw_valid_o(aw_valid), .axi_aw_ready_i(aw_ready), .axi_aw_id_o(aw_id),
    .axi_aw_addr_o(aw_addr), .axi_aw_len_o(aw_len), .axi_aw_size_o(aw_size),
    .axi_aw_burst_o(aw_burst),
    .axi_w_valid_o(w_valid), .axi_w_ready_i(w_ready), .axi_w_data_o(w_data),
    .axi_w_strb_o(w_strb), .axi_w_last_o(w_last),
    .axi_b_valid_i(b_valid), .axi_b_ready_o(b_ready), .axi_b_id_i(b_id), .axi_b_resp_i(b_resp),
    .axi_ar_valid_o(ar_valid), .axi_ar_ready_i(ar_ready), .axi_ar_id_o(ar_id),
    .axi_ar_addr_o(ar_addr), .axi_ar_len_o(ar_len), .axi_ar_size_o(ar_size),
    .axi_ar_burst_o(ar_burst),
    .axi_r_valid_i(r_valid), .axi_r_ready_o(r_ready), .axi_r_id_i(r_id), .axi_r_resp_i(r_resp),
    .axi_r_data_i(r_data), .axi_r_last_i(r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // transaction-level model state
  bit          mon_en = 1'b0, m_busy = 1'b0;
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_wstrb;
  logic        m_err;

  // slave configuration and observed handshake counts
  int          c_ar, c_r, c_aw, c_w, c_b;
  logic [63:0] c_rdata;
  logic [1:0]  c_resp;
  int          n_ar, n_r, n_aw, n_w, n_b;

  initial begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, got_aw, got_w;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    rd_pend = 0; got_aw = 0; got_w = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
    r_data = '0; r_resp = 2'd0; b_resp = 2'd0; r_id = '0; b_id = '0; r_last = 1'b1;
    forever begin
      @(negedge clk);
      ar_hs = ar_valid & ar_ready; r_hs = r_valid & r_ready;
      aw_hs = aw_valid & aw_ready; w_hs = w_valid & w_ready; b_hs = b_valid & b_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        rd_pend = 0; got_aw = 0; got_w = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
      end else begin
        if (ar_hs) begin n_ar++; rd_pend = 1; r_cnt = 0; ar_cnt = 0; end
        if (r_hs)  begin n_r++; rd_pend = 0; end
        if (aw_hs) begin n_aw++; got_aw = 1; aw_cnt = 0; end
        if (w_hs)  begin n_w++; got_w = 1; w_cnt = 0; end
        if (b_hs)  begin n_b++; got_aw = 0; got_w = 0; b_cnt = 0; end
        ar_ready = 0;
        if (ar_valid) begin ar_ready = (ar_cnt >= c_ar); if (ar_cnt < c_ar) ar_cnt++; end
        aw_ready = 0;
        if (aw_valid) begin aw_ready = (aw_cnt >= c_aw); if (aw_cnt < c_aw) aw_cnt++; end
        w_ready = 0;
        if (w_valid) begin w_ready = (w_cnt >= c_w); if (w_cnt < c_w) w_cnt++; end
        r_valid = 0; r_data = 64'hDEAD_BEEF_0BAD_F00D; r_resp = 2'd3;
        if (rd_pend) begin
          if (r_cnt >= c_r) begin r_valid = 1; r_data = c_rdata; r_resp = c_resp; end
          else r_cnt++;
        end
        b_valid = 0; b_resp = 2'd3;
        if (got_aw && got_w) begin
          if (b_cnt >= c_b) begin b_valid = 1; b_resp = c_resp; end
          else b_cnt++;
        end
      end
    end
  end

  // per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("req_ready", req_ready, !m_busy);
      if (ar_valid) begin
        chk("ar_addr", ar_addr, m_addr);
        chk("ar_size", ar_size, m_size);
        chk("ar_len", ar_len, 8'd0);
        chk("ar_burst", ar_burst, 2'b01);
        chk("ar_id", ar_id, 4'd0);
      end
      if (aw_valid) begin
        chk("aw_addr", aw_addr, m_addr);
        chk("aw_size", aw_size, m_size);
        chk("aw_len", aw_len, 8'd0);
        chk("aw_burst", aw_burst, 2'b01);
        chk("aw_id", aw_id, 4'd0);
      end
      if (w_valid) begin
        chk("w_data", w_data, m_wdata);
        chk("w_strb", w_strb, m_wstrb);
        chk("w_last", w_last, 1'b1);
      end
      if (rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        chk("no_issue_in_rsp", {ar_valid, aw_valid, w_valid}, 3'b000);
      end
    end
  end

  task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] size,
                     input logic [63:0] wd, input logic [7:0] ws,
                     input int dar, input int dr, input int daw, input int dw, input int db,
                     input logic [63:0] rd, input logic [1:0] resp, input int hold, input bit keep,
                     output int lat, output logic [63:0] got_d, output logic got_e);
    bit bad, got;
    int exp_lat;
    bad = 0;
`ifdef YSYX_22050133_AXI_MST_ALIGN_CHECK_EN
    bad = (addr & ((32'd1 << size) - 32'd1)) != 32'd0;
`endif
    c_ar = dar; c_r = dr; c_aw = daw; c_w = dw; c_b = db; c_rdata = rd; c_resp = resp;
    m_addr = addr; m_size = size; m_wdata = wd; m_wstrb = ws;
    m_rdata = (we || bad) ? 64'd0 : rd;
    m_err   = bad ? 1'b1 : (resp != 2'd0);
    exp_lat = bad ? 1 : we ? 3 + ((daw > dw) ? daw : dw) + db : 3 + dar + dr;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
    req_we = we; req_addr = addr; req_size = size; req_wdata = wd; req_wstrb = ws;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
    m_busy = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++;
      if (rsp_valid) got = 1;
    end
    if (!got) chk("rsp_timeout", 1'b0, 1'b1);
    got_d = rsp_rdata; got_e = rsp_err;
    chk("latency", lat, exp_lat);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0; m_busy = 1'b0;
    chk("n_ar", n_ar, (!we && !bad) ? 1 : 0);
    chk("n_r",  n_r,  (!we && !bad) ? 1 : 0);
    chk("n_aw", n_aw, (we && !bad) ? 1 : 0);
    chk("n_w",  n_w,  (we && !bad) ? 1 : 0);
    chk("n_b",  n_b,  (we && !bad) ? 1 : 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_valids"}, {ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid}, 6'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, k;
    logic [63:0] d;
    logic e;
    logic [31:0] a;
    logic [2:0] s;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 0;
    c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_b = 0; c_rdata = '0; c_resp = '0;
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // CLINT mtime-style load, zero wait states
    txn(1'b0, 32'h0200_BFF8, 3'd3, 64'd0, 8'h00, 0, 0, 0, 0, 0, 64'h1234, 2'b00, 0, 0, lat, d, e);
    chk("t1_lat", lat, 3);
    chk("t1_rdata", d, 64'h1234);
    chk("t1_err", e, 1'b0);

    // store, AW accepted two cycles before W
    txn(1'b1, 32'h0200_4000, 3'd3, 64'h64, 8'hFF, 0, 0, 0, 2, 0, 64'd0, 2'b00, 0, 0, lat, d, e);
    chk("t2_lat", lat, 5);
    chk("t2_err", e, 1'b0);
    chk("t2_rdata", d, 64'd0);

    // store, same-cycle AW/W, SLVERR
    txn(1'b1, 32'h8000_0010, 3'd2, 64'h1111_2222_3333_4444, 8'h0F, 0, 0, 0, 0, 0,
        64'd0, 2'b10, 0, 0, lat, d, e);
    chk("t3_lat", lat, 3);
    chk("t3_err", e, 1'b1);
    chk("t3_rdata", d, 64'd0);

    // response held off 5 cycles with a request pending
    txn(1'b0, 32'h8000_0100, 3'd3, 64'd0, 8'h00, 1, 1, 0, 0, 0, 64'hCAFE_F00D_1234_5678,
        2'b00, 5, 1, lat, d, e);
    chk("t4_rdata", d, 64'hCAFE_F00D_1234_5678);

    // reset while waiting in R
    c_ar = 0; c_r = 8; c_rdata = 64'h5555; c_resp = 2'b00;
    m_addr = 32'h8000_0200; m_size = 3'd3;
    req_we = 0; req_addr = 32'h8000_0200; req_size = 3'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; m_busy = 1'b1;
    k = 0;
    while (!r_ready && k < 20) begin @(negedge clk); k++; end
    chk("reach_r_state", r_ready, 1'b1);
    #2 mon_en = 1'b0; rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    m_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h8000_0300, 3'd3, 64'd0, 8'h00, 0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF,
        2'b00, 0, 0, lat, d, e);
    chk("t5_lat", lat, 3);
    chk("t5_rdata", d, 64'h0123_4567_89AB_CDEF);

    // misaligned word load
    txn(1'b0, 32'h0000_1003, 3'd2, 64'd0, 8'h00, 0, 0, 0, 0, 0, 64'h77, 2'b00, 0, 0, lat, d, e);
`ifdef YSYX_22050133_AXI_MST_ALIGN_CHECK_EN
    chk("t6_lat", lat, 1);
    chk("t6_err", e, 1'b1);
    chk("t6_rdata", d, 64'd0);
`else
    chk("t6_lat", lat, 3);
    chk("t6_rdata", d, 64'h77);
`endif

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      s = 3'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      txn(1'($urandom), a, s, {$urandom, $urandom}, 8'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
          2'($urandom), $urandom_range(0, 2), 1'($urandom), lat, d, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
